seq_alu: RTL

Parametrised multi-cycle successor to the single-cycle datapath ALU, for the pipelined/multi-cycle RISC-V core.
- Single-cycle integer ops return a registered result with 1-cycle latency.
- MUL/MULHU use an iterative shift-add engine; DIVU/REMU use an iterative restoring divider.
- Operands enter over a valid/ready handshake; result and flags leave over a second valid/ready handshake.
- Zero, sign, carry, overflow and illegal-op flags are registered alongside the result.

---
 rtl/seq_alu_pkg.sv | 40 ++++
 rtl/seq_alu_if.sv | 30 +++
 rtl/seq_alu_iter.sv | 83 ++++++++
 rtl/seq_alu.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states, opcode helpers.
// Optional divider is selected by the SEQ_ALU_DIV_EN macro.
package seq_alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SLL   = 4'b0001;
    localparam logic [3:0] ALU_SUB   = 4'b0010;
    localparam logic [3:0] ALU_SLT   = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_AND   = 4'b0111;
    localparam logic [3:0] ALU_SRA   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1100;
    localparam logic [3:0] ALU_MULHU = 4'b1101;
    localparam logic [3:0] ALU_DIVU  = 4'b1110;
    localparam logic [3:0] ALU_REMU  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Without the divider, DIVU/REMU fall back to the single-cycle illegal path.
    function automatic logic is_iterative(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
    endfunction

    // High half of the accumulator holds the MULHU product and the REMU remainder.
    function automatic logic selects_high(input logic [3:0] op);
        return (op == ALU_MULHU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/response bus of the multi-cycle ALU, with master (requester) and slave (ALU) views.
interface seq_alu_if #(
    parameter int WIDTH = 32
);
    // Both channels: a transfer happens on a rising edge where valid & ready are high;
    // valid and its payload stay stable until that transfer, ready may change freely.
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUControl;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             sign_flag;
    logic             carry_flag;
    logic             overflow_flag;
    logic             illegal_op;

    modport master (
        output in_valid, ALUControl, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, sign_flag, carry_flag, overflow_flag, illegal_op
    );

    modport slave (
        input  in_valid, ALUControl, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, sign_flag, carry_flag, overflow_flag, illegal_op
    );
endinterface

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider sharing one
// 2*WIDTH accumulator; done flags the cycle whose step produces the final res_hi/res_lo.
module seq_alu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef SEQ_ALU_DIV_EN
    input  logic             div_mode,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int SHW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   m_q;
    logic [SHW-1:0]     cnt_q;
    logic               busy_q;
    logic [WIDTH:0]     mul_sum;
`ifdef SEQ_ALU_DIV_EN
    logic               div_q;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [WIDTH-1:0]   rem_diff;
`endif

    // Multiply: {hi,lo} starts as {0, multiplier}; add multiplicand on lo[0], shift right.
    // Divide:   {hi,lo} starts as {0, dividend}; shift left, trial-subtract, shift in quotient bit.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
        acc_d   = {mul_sum, acc_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        rem_ge   = rem_sh >= {1'b0, m_q};
        rem_diff = rem_sh[WIDTH-1:0] - m_q;
        if (div_q) begin
            acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        end
`endif
    end

    assign done   = busy_q && (cnt_q == '0);
    assign res_hi = acc_d[2*WIDTH-1:WIDTH];
    assign res_lo = acc_d[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            m_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= 1'b0;
`endif
        end else if (start) begin
            acc_q  <= {{WIDTH{1'b0}}, b};
            m_q    <= a;
`ifdef SEQ_ALU_DIV_EN
            div_q  <= div_mode;
            if (div_mode) begin
                acc_q <= {{WIDTH{1'b0}}, a};
                m_q   <= b;
            end
`endif
            cnt_q  <= SHW'(WIDTH - 1);
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q <= acc_d;
            if (cnt_q == '0) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - SHW'(1);
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU top: request/response handshakes, IDLE/BUSY/DONE FSM, single-cycle
// datapath and registered flags. DIVU/REMU are built only when SEQ_ALU_DIV_EN is defined.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    seq_alu_if.slave      bus,
    output state_t        dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, sign_q, carry_q, ovf_q, illegal_q;
    logic             hi_sel_q;

    logic             accept;
    logic             iter_start;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi, iter_lo;

    logic [WIDTH-1:0] a, b;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   add_full, sub_full;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry, sc_ovf, sc_illegal;

    logic [WIDTH-1:0] fin_result;
    logic             fin_carry, fin_ovf, fin_illegal;

    assign accept     = bus.in_valid && in_ready_q;
    assign iter_start = accept && is_iterative(bus.ALUControl);

    assign a        = bus.SrcA;
    assign b        = bus.SrcB;
    assign shamt    = b[SHW-1:0];
    assign add_full = {1'b0, a} + {1'b0, b};
    assign sub_full = {1'b0, a} - {1'b0, b};

    // Single-cycle ops are evaluated straight off the inputs and captured on the accept edge.
    always_comb begin
        sc_result  = '0;
        sc_carry   = 1'b0;
        sc_ovf     = 1'b0;
        sc_illegal = 1'b0;
        case (bus.ALUControl)
            ALU_ADD: begin
                sc_result = add_full[WIDTH-1:0];
                sc_carry  = add_full[WIDTH];
                sc_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = sub_full[WIDTH-1:0];
                sc_carry  = ~sub_full[WIDTH];
                sc_ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (sc_result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SLL:  sc_result = a << shamt;
            ALU_SRL:  sc_result = a >> shamt;
            ALU_SRA:  sc_result = $unsigned($signed(a) >>> shamt);
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_XOR:  sc_result = a ^ b;
            ALU_OR:   sc_result = a | b;
            ALU_AND:  sc_result = a & b;
            default:  sc_illegal = 1'b1;
        endcase
    end

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (iter_start),
`ifdef SEQ_ALU_DIV_EN
        .div_mode ((bus.ALUControl == ALU_DIVU) || (bus.ALUControl == ALU_REMU)),
`endif
        .a        (a),
        .b        (b),
        .done     (iter_done),
        .res_hi   (iter_hi),
        .res_lo   (iter_lo)
    );

    always_comb begin
        if (state_q == BUSY) begin
            fin_result  = hi_sel_q ? iter_hi : iter_lo;
            fin_carry   = 1'b0;
            fin_ovf     = 1'b0;
            fin_illegal = 1'b0;
        end else begin
            fin_result  = sc_result;
            fin_carry   = sc_carry;
            fin_ovf     = sc_ovf;
            fin_illegal = sc_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            sign_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            hi_sel_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        hi_sel_q   <= selects_high(bus.ALUControl);
                        if (is_iterative(bus.ALUControl)) begin
                            state_q <= BUSY;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= fin_result;
                            zero_q      <= (fin_result == '0);
                            sign_q      <= fin_result[WIDTH-1];
                            carry_q     <= fin_carry;
                            ovf_q       <= fin_ovf;
                            illegal_q   <= fin_illegal;
                        end
                    end
                end
                BUSY: begin
                    if (iter_done) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fin_result;
                        zero_q      <= (fin_result == '0);
                        sign_q      <= fin_result[WIDTH-1];
                        carry_q     <= fin_carry;
                        ovf_q       <= fin_ovf;
                        illegal_q   <= fin_illegal;
                    end
                end
                DONE: begin
                    // Result stays held until consumed; readiness returns on the consume edge.
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.ALUResult     = result_q;
    assign bus.Zero          = zero_q;
    assign bus.sign_flag     = sign_q;
    assign bus.carry_flag    = carry_q;
    assign bus.overflow_flag = ovf_q;
    assign bus.illegal_op    = illegal_q;
    assign dbg_state         = state_q;

endmodule
